// File: rtl/pll_reset_ctrl.sv
// pll_reset_ctrl: sequences the SNES main clock PLL and derives the core reset.
//   Holds the PLL in reset, waits for lock (retrying on timeout), debounces
//   lock, then releases the core. A loss of lock while running restarts the
//   sequence.
// Optional feature macro: PLL_FAIL_HALT_EN (halt in FAIL after MAX_RETRY timeouts).
// Ports:
//   clkin      in   27 MHz board clock, rising edge
//   reset      in   asynchronous active-high block reset
//   lock       in   PLL lock, asynchronous to clkin
//   pll_reset  out  active-high PLL reset
//   sys_reset  out  active-high SNES core reset
//   ready      out  high while running
//   fail       out  high while halted after too many timeouts
//   retries    out  lock timeouts since reset, saturating at 15
module pll_reset_ctrl #(
    parameter int unsigned RST_CYCLES   = 16,
    parameter int unsigned LOCK_TIMEOUT = 65536,
    parameter int unsigned LOCK_STABLE  = 1024,
    parameter int unsigned MAX_RETRY    = 4
) (
    input  logic       clkin,
    input  logic       reset,
    input  logic       lock,
    output logic       pll_reset,
    output logic       sys_reset,
    output logic       ready,
    output logic       fail,
    output logic [3:0] retries
);

    localparam int unsigned CNT_MAX_A = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int unsigned CNT_MAX   = (CNT_MAX_A > LOCK_STABLE) ? CNT_MAX_A : LOCK_STABLE;
    localparam int unsigned CW        = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

    // Elaboration-time parameter range checks
    if (RST_CYCLES < 2) begin : g_chk_rst
        $error("RST_CYCLES must be at least 2");
    end
    if (MAX_RETRY < 1 || MAX_RETRY > 15) begin : g_chk_retry
        $error("MAX_RETRY must be within 1..15");
    end

    typedef enum logic [2:0] {
        S_HOLD   = 3'd0,
        S_WAIT   = 3'd1,
        S_STABLE = 3'd2,
`ifdef PLL_FAIL_HALT_EN
        S_FAIL   = 3'd4,
`endif
        S_RUN    = 3'd3
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [3:0]      retries_d;
    logic            lock_m, lock_s;

    // Two-flop synchronizer for the asynchronous lock input
    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            lock_m <= 1'b0;
            lock_s <= 1'b0;
        end else begin
            lock_m <= lock;
            lock_s <= lock_m;
        end
    end

    // State, shared counter, retry count and registered outputs
    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            state_q   <= S_HOLD;
            cnt_q     <= '0;
            retries   <= 4'd0;
            pll_reset <= 1'b1;
            sys_reset <= 1'b1;
            ready     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retries   <= retries_d;
            // Outputs decode the next state so they move with the state register
`ifdef PLL_FAIL_HALT_EN
            pll_reset <= (state_d == S_HOLD) || (state_d == S_FAIL);
`else
            pll_reset <= (state_d == S_HOLD);
`endif
            sys_reset <= (state_d != S_RUN);
            ready     <= (state_d == S_RUN);
        end
    end

`ifdef PLL_FAIL_HALT_EN
    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            fail <= 1'b0;
        end else begin
            fail <= (state_d == S_FAIL);
        end
    end
`else
    assign fail = 1'b0;
`endif

    // Next-state decode
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CW'(1);
        retries_d = retries;
        case (state_q)
            S_HOLD: begin
                if (cnt_q == CW'(RST_CYCLES - 1)) state_d = S_WAIT;
            end
            S_WAIT: begin
                // Lock seen in the timeout cycle wins over the timeout
                if (lock_s) begin
                    state_d = S_STABLE;
                end else if (cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
                    if (retries != 4'd15) retries_d = retries + 4'd1;
                    state_d = S_HOLD;
`ifdef PLL_FAIL_HALT_EN
                    if (retries_d == 4'(MAX_RETRY)) state_d = S_FAIL;
`endif
                end
            end
            S_STABLE: begin
                // A drop on the final debounce cycle still returns to WAIT
                if (!lock_s) begin
                    state_d = S_WAIT;
                end else if (cnt_q == CW'(LOCK_STABLE - 1)) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (!lock_s) state_d = S_HOLD;
            end
`ifdef PLL_FAIL_HALT_EN
            S_FAIL: begin
                cnt_d = cnt_q;
            end
`endif
            default: state_d = S_HOLD;
        endcase
        if (state_d != state_q) cnt_d = '0;
    end

endmodule

// File: tb/tb_pll_reset_ctrl.sv
// Testbench for pll_reset_ctrl with RST_CYCLES=4, LOCK_TIMEOUT=32,
// LOCK_STABLE=8, MAX_RETRY=3. Honours PLL_FAIL_HALT_EN if defined.
module tb_pll_reset_ctrl;

    typedef struct {
        logic       lock;
        int         adv;
        logic       pll;
        logic       sys;
        logic       rdy;
        logic       fl;
        logic [3:0] ret;
    } vec_t;

    logic       clkin;
    logic       reset;
    logic       lock;
    logic       pll_reset;
    logic       sys_reset;
    logic       ready;
    logic       fail;
    logic [3:0] retries;

    int errors = 0;
    int checks = 0;

    vec_t tbl[$];
    vec_t exp_q[$];

    pll_reset_ctrl #(
        .RST_CYCLES  (4),
        .LOCK_TIMEOUT(32),
        .LOCK_STABLE (8),
        .MAX_RETRY   (3)
    ) dut (
        .clkin    (clkin),
        .reset    (reset),
        .lock     (lock),
        .pll_reset(pll_reset),
        .sys_reset(sys_reset),
        .ready    (ready),
        .fail     (fail),
        .retries  (retries)
    );

    initial clkin = 1'b0;
    always #5 clkin = ~clkin;

    // Pop the oldest expectation and compare it with the current outputs
    task automatic check_out(input string name);
        vec_t e;
        e = exp_q.pop_front();
        checks++;
        if (pll_reset !== e.pll || sys_reset !== e.sys || ready !== e.rdy ||
            fail !== e.fl || retries !== e.ret) begin
            errors++;
            $display("FAIL %s: got pll=%b sys=%b rdy=%b fail=%b ret=%0d, want pll=%b sys=%b rdy=%b fail=%b ret=%0d",
                     name, pll_reset, sys_reset, ready, fail, retries,
                     e.pll, e.sys, e.rdy, e.fl, e.ret);
        end
    endtask

    // Drive lock, advance adv rising edges, sample on the following falling edge
    task automatic apply(input vec_t v, input string name);
        exp_q.push_back(v);
        lock = v.lock;
        repeat (v.adv) @(posedge clkin);
        @(negedge clkin);
        check_out(name);
    endtask

    // Check outputs right now without advancing the clock
    task automatic expect_now(input logic p, input logic s, input logic r,
                              input logic f, input logic [3:0] rt, input string name);
        exp_q.push_back(vec_t'{lock, 0, p, s, r, f, rt});
        check_out(name);
    endtask

    task automatic wait_ready(input int max_cyc, input string name);
        int n;
        n = 0;
        while (!ready && n < max_cyc) begin
            @(negedge clkin);
            n++;
        end
        checks++;
        if (!ready) begin
            errors++;
            $display("FAIL %s: ready still %b after %0d cycles, want 1", name, ready, max_cyc);
        end
    endtask

    task automatic run_table(input string tag);
        foreach (tbl[i]) apply(tbl[i], $sformatf("%s_vec%0d", tag, i));
    endtask

    // Release reset on a falling edge so the next rising edge is cycle 1
    task automatic release_reset();
        @(negedge clkin);
        reset = 1'b0;
    endtask

    function automatic logic [3:0] sat(input int k);
        return (k > 15) ? 4'd15 : 4'(k);
    endfunction

    initial begin
        // Timeline from reset release; Pn is the n-th rising edge
        tbl.push_back(vec_t'{1'b0,  1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0}); // P1  HOLD
        tbl.push_back(vec_t'{1'b0,  2, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0}); // P3  HOLD last
        tbl.push_back(vec_t'{1'b0,  1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0}); // P4  WAIT
        tbl.push_back(vec_t'{1'b1, 10, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0}); // P14 STABLE
        tbl.push_back(vec_t'{1'b1,  1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0}); // P15 RUN (11 after fall)
        tbl.push_back(vec_t'{1'b1, 20, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0}); // P35 RUN
        tbl.push_back(vec_t'{1'b0,  2, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0}); // P37 sync delay
        tbl.push_back(vec_t'{1'b0,  1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0}); // P38 HOLD on 3rd edge
        tbl.push_back(vec_t'{1'b0,  3, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0}); // P41
        tbl.push_back(vec_t'{1'b0,  1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0}); // P42 WAIT
        tbl.push_back(vec_t'{1'b0, 31, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0}); // P73
        tbl.push_back(vec_t'{1'b0,  1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd1}); // P74 timeout
        tbl.push_back(vec_t'{1'b0,  3, 1'b1, 1'b1, 1'b0, 1'b0, 4'd1}); // P77
        tbl.push_back(vec_t'{1'b0,  1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1}); // P78 WAIT
        tbl.push_back(vec_t'{1'b1,  5, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1}); // P83 glitch high
        tbl.push_back(vec_t'{1'b0,  5, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1}); // P88 back in WAIT
        tbl.push_back(vec_t'{1'b0,  1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1}); // P89 no RUN
        tbl.push_back(vec_t'{1'b1, 10, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1}); // P99
        tbl.push_back(vec_t'{1'b1,  1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1}); // P100 RUN
        tbl.push_back(vec_t'{1'b0,  2, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1}); // P102
        tbl.push_back(vec_t'{1'b0,  1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd1}); // P103 HOLD
        tbl.push_back(vec_t'{1'b0,  3, 1'b1, 1'b1, 1'b0, 1'b0, 4'd1}); // P106
        tbl.push_back(vec_t'{1'b0,  1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1}); // P107 WAIT
        tbl.push_back(vec_t'{1'b0, 29, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1}); // P136
        tbl.push_back(vec_t'{1'b1,  3, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1}); // P139 lock wins timeout
        tbl.push_back(vec_t'{1'b1,  1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1}); // P140 STABLE
        tbl.push_back(vec_t'{1'b1,  4, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1}); // P144
        tbl.push_back(vec_t'{1'b0,  3, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1}); // P147 drop on last cycle
        tbl.push_back(vec_t'{1'b0,  1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1}); // P148 WAIT
        tbl.push_back(vec_t'{1'b0, 30, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1}); // P178
        tbl.push_back(vec_t'{1'b0,  1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd2}); // P179 timeout

        reset = 1'b1;
        lock  = 1'b0;
        repeat (3) @(posedge clkin);
        @(negedge clkin);
        expect_now(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, "reset_values");
        release_reset();
        run_table("first");

        // Asynchronous reset while running, then full replay
        lock = 1'b1;
        wait_ready(40, "reach_run");
        @(negedge clkin);
        #2 reset = 1'b1;
        #1 expect_now(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, "async_rst_run");
        lock = 1'b0;
        release_reset();
        run_table("replay");

        // Asynchronous reset while debouncing in STABLE
        lock = 1'b1;
        repeat (6) @(negedge clkin);
        expect_now(1'b0, 1'b1, 1'b0, 1'b0, 4'd2, "in_stable");
        #2 reset = 1'b1;
        #1 expect_now(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, "async_rst_stable");
        lock = 1'b0;
        release_reset();

        // Lock never arrives: 36-cycle retry period, saturation or halt
        for (int k = 1; k <= 17; k++) begin
`ifdef PLL_FAIL_HALT_EN
            apply(vec_t'{1'b0, 35, 1'b0, 1'b1, 1'b0, 1'b0, sat(k - 1)}, $sformatf("nolock_low%0d", k));
            if (k == 3) begin
                apply(vec_t'{1'b0, 1, 1'b1, 1'b1, 1'b0, 1'b1, 4'd3}, "enter_fail");
                for (int j = 0; j < 10; j++)
                    apply(vec_t'{1'b0, 100, 1'b1, 1'b1, 1'b0, 1'b1, 4'd3}, $sformatf("fail_hold%0d", j));
                break;
            end
            apply(vec_t'{1'b0, 1, 1'b1, 1'b1, 1'b0, 1'b0, sat(k)}, $sformatf("nolock_high%0d", k));
`else
            apply(vec_t'{1'b0, 35, 1'b0, 1'b1, 1'b0, 1'b0, sat(k - 1)}, $sformatf("nolock_low%0d", k));
            apply(vec_t'{1'b0, 1, 1'b1, 1'b1, 1'b0, 1'b0, sat(k)}, $sformatf("nolock_high%0d", k));
`endif
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
